// File: rtl/alu_seq_wide.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_wide
// Purpose  : Byte-serial sequential ALU. Operands A and B and a 3-bit opcode
//            are shifted in one byte at a time. A start command runs one
//            operation: single-cycle ADD/SUB/logic/shift ops, or an
//            iterative shift-add multiply that takes WIDTH cycles. The result
//            is read back one byte at a time through a read pointer.
// Ports    : clk      - single clock, rising edge
//            rst_n    - synchronous active-low reset
//            ena      - clock enable, low freezes all state
//            ui_in    - data byte for operand/opcode loads
//            uio_in   - [0] load, [2:1] target (A/B/OP/read-advance), [3] start
//            uo_out   - result byte selected by the read pointer
//            uio_out  - [4] busy, [5] done, [6] carry, [7] overflow
//            uio_oe   - constant 8'hF0 (upper nibble driven)
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq_wide #(
    parameter int WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int NBYTES = WIDTH / 8;
    localparam int SHW    = $clog2(WIDTH);
    localparam int PTRW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int CNTW   = SHW;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_exec = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    localparam logic [2:0] c_op_add = 3'b000;
    localparam logic [2:0] c_op_sub = 3'b001;
    localparam logic [2:0] c_op_and = 3'b010;
    localparam logic [2:0] c_op_or  = 3'b011;
    localparam logic [2:0] c_op_xor = 3'b100;
    localparam logic [2:0] c_op_shl = 3'b101;
    localparam logic [2:0] c_op_shr = 3'b110;
    localparam logic [2:0] c_op_mul = 3'b111;

    localparam logic [1:0] c_tgt_a   = 2'b00;
    localparam logic [1:0] c_tgt_b   = 2'b01;
    localparam logic [1:0] c_tgt_op  = 2'b10;
    localparam logic [1:0] c_tgt_adv = 2'b11;

    localparam logic [PTRW-1:0] c_ptr_last = PTRW'(NBYTES - 1);
    localparam logic [CNTW-1:0] c_cnt_last = CNTW'(WIDTH - 1);

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2:0]         r_op;
    logic [WIDTH-1:0]   r_r;
    logic               r_carry;
    logic               r_ovf;
    logic [PTRW-1:0]    r_ptr;
    logic [CNTW-1:0]    r_cnt;
    logic [2*WIDTH-1:0] r_acc;

    logic               w_load;
    logic [1:0]         w_tgt;
    logic               w_start;
    logic [3:0]         w_unused_ctrl;
    logic [SHW-1:0]     w_shamt;
    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_sub;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0]   w_res;
    logic               w_c;
    logic               w_v;

    assign w_load        = uio_in[0];
    assign w_tgt         = uio_in[2:1];
    assign w_start       = uio_in[3];
    assign w_unused_ctrl = uio_in[7:4];
    assign w_shamt       = r_b[SHW-1:0];

    assign w_add = {1'b0, r_a} + {1'b0, r_b};
    assign w_sub = {1'b0, r_a} - {1'b0, r_b};

    // Multiply step: the low half of the accumulator holds the remaining
    // multiplier bits (LSB first). Add A into the upper half when the current
    // multiplier bit is set, then shift the whole accumulator right by one.
    // The extra sum bit becomes the new MSB, so nothing is lost.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
    assign w_acc_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Single-cycle operations
    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (r_op)
            c_op_add: begin
                w_res = w_add[WIDTH-1:0];
                w_c   = w_add[WIDTH];
                w_v   = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_add[WIDTH-1] != r_a[WIDTH-1]);
            end
            c_op_sub: begin
                w_res = w_sub[WIDTH-1:0];
                w_c   = w_sub[WIDTH];  // borrow
                w_v   = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_sub[WIDTH-1] != r_a[WIDTH-1]);
            end
            c_op_and: w_res = r_a & r_b;
            c_op_or:  w_res = r_a | r_b;
            c_op_xor: w_res = r_a ^ r_b;
            // Amounts >= WIDTH (possible when WIDTH is not a power of two)
            // shift everything out and give zero.
            c_op_shl: w_res = r_a << w_shamt;
            c_op_shr: w_res = r_a >> w_shamt;
            default:  w_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= c_op_add;
            r_r     <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_acc   <= '0;
        end else if (ena) begin
            case (r_state)
                c_st_idle, c_st_done: begin
                    // A load in the same cycle as start wins; start is dropped.
                    if (w_load) begin
                        case (w_tgt)
                            c_tgt_a:  r_a  <= {ui_in, r_a[WIDTH-1:8]};
                            c_tgt_b:  r_b  <= {ui_in, r_b[WIDTH-1:8]};
                            c_tgt_op: r_op <= ui_in[2:0];
                            c_tgt_adv: begin
                                if (r_state == c_st_done) begin
                                    r_ptr <= (r_ptr == c_ptr_last) ? '0 : r_ptr + 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end else if (w_start) begin
                        r_state <= c_st_exec;
                        r_cnt   <= '0;
                        r_acc   <= {{WIDTH{1'b0}}, r_b};
                    end
                end
                c_st_exec: begin
                    if (r_op == c_op_mul) begin
                        r_acc <= w_acc_next;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == c_cnt_last) begin
                            r_r     <= w_acc_next[WIDTH-1:0];
                            r_carry <= 1'b0;
                            r_ovf   <= |w_acc_next[2*WIDTH-1:WIDTH];
                            r_ptr   <= '0;
                            r_state <= c_st_done;
                        end
                    end else begin
                        r_r     <= w_res;
                        r_carry <= w_c;
                        r_ovf   <= w_v;
                        r_ptr   <= '0;
                        r_state <= c_st_done;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign uo_out  = r_r[{r_ptr, 3'b000} +: 8];
    assign uio_out = {r_ovf, r_carry, (r_state == c_st_done), (r_state == c_st_exec), 4'b0000};
    assign uio_oe  = 8'hF0;

endmodule
`default_nettype wire

// File: doc/alu_seq_wide.md
ALU_SEQ_WIDE -- requirements
Module: alu_seq_wide

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits; legal values 8, 16, 24, 32 (multiple of 8).
REQ-002 SHALL derive NBYTES = WIDTH/8 and SHW = clog2(WIDTH), both local, not overridable.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 ena  input  1  clock enable; low freezes all state.
REQ-006 ui_in  input  8  data byte for operand/opcode load.
REQ-007 uio_in  input  8  control: [0] load strobe, [2:1] target (00 A, 01 B, 10 OP, 11 read-advance), [3] start, [7:4] ignored.
REQ-008 uo_out  output  8  result byte selected by read pointer.
REQ-009 uio_out  output  8  [3:0] 0, [4] busy, [5] done, [6] carry, [7] overflow.
REQ-010 uio_oe  output  8  constant 8'hF0.

Function
REQ-011 Operand load: load=1, target A (or B), state not EXEC -> A <= {ui_in, A[WIDTH-1:8]}; after NBYTES loads the first byte sent is A[7:0].
REQ-012 Opcode load: load=1, target OP, state not EXEC -> OP <= ui_in[2:0].
REQ-013 Opcodes: 000 ADD, 001 SUB (A-B), 010 AND, 011 OR, 100 XOR, 101 SHL A by B[SHW-1:0], 110 SHR logical A by B[SHW-1:0], 111 MUL (low WIDTH bits of A*B, unsigned).
REQ-014 FSM states IDLE, EXEC, DONE; IDLE->EXEC and DONE->EXEC on start=1 with load=0.
REQ-015 Start together with load=1 in the same cycle: load takes effect, start ignored.
REQ-016 Opcodes 000-110: EXEC lasts exactly 1 cycle; R and flags written at end of it; DONE the following cycle (start edge to done = 2 cycles).
REQ-017 MUL: iterative shift-add over 2*WIDTH-bit accumulator, exactly WIDTH EXEC cycles; done asserted on cycle WIDTH+1 after start.
REQ-018 busy = 1 exactly while in EXEC; done = 1 exactly while in DONE.
REQ-019 In EXEC, load, start and read-advance are ignored; A, B, OP held.
REQ-020 Flags: ADD carry = bit WIDTH of A+B, overflow = signed overflow; SUB carry = borrow (A<B unsigned), overflow = signed overflow; MUL carry = 0, overflow = high WIDTH product bits nonzero; logic/shift ops carry = 0, overflow = 0.
REQ-021 Shift amount uses only B[SHW-1:0]; WIDTH=24 amounts 24-31 yield R=0.
REQ-022 Read pointer set to 0 on every entry to DONE; uo_out = R[8*ptr+7 : 8*ptr].
REQ-023 load=1 with target 11 in DONE increments ptr; NBYTES-1 wraps to 0; ignored in IDLE and EXEC.
REQ-024 Operand/opcode loads in DONE permitted; state stays DONE, R and flags unchanged until next start.
REQ-025 ena=0 overrides everything except reset: no state, pointer, counter or register change.

Reset
REQ-026 rst_n=0 at a clock edge SHALL set state IDLE, A=B=R=0, OP=000, carry=overflow=0, ptr=0, MUL counter/accumulator 0, regardless of ena.
REQ-027 Reset mid-EXEC (including MUL) SHALL abort; no partial result retained; busy=0, done=0, uo_out=0 the cycle after reset.
REQ-028 uio_oe SHALL be 8'hF0 during and after reset.

Verification (WIDTH=16)
REQ-029 Load A=0xFFFF, B=0x0001, OP=000, start -> done 2 cycles later, R=0x0000, carry=1, overflow=0; reads 0x00,0x00.
REQ-030 A=0x0000, B=0x0001, OP=001 -> R=0xFFFF, carry=1, overflow=0; A=0x8000, B=0x0001 -> R=0x7FFF, overflow=1.
REQ-031 A=0x0100, B=0x0100, OP=111 -> busy for exactly 16 cycles, R=0x0000, overflow=1; A=0x0012, B=0x0034 -> R=0x03A8, overflow=0.
REQ-032 A=0x8001, B=0x0011, OP=101 -> R=0x0002; OP=110 -> R=0x4000; read-advance x3 -> uo_out 0x00,0x40,0x00 wrap.
REQ-033 Start with load in same cycle -> operand updated, state stays IDLE; ena=0 for 5 cycles mid-MUL -> completion delayed exactly 5 cycles, same R.
REQ-034 rst_n=0 at MUL cycle 7 -> next cycle busy=0, done=0, R=0, uo_out=0; fresh ADD afterwards correct.
